// File: rtl/cache_mem_arbiter.sv
// Two-client line-memory arbiter: I-cache and D-cache onto one pmem port.
// Define ARB_ROUND_ROBIN_EN for alternating priority; otherwise the D-cache wins on contention.
module cache_mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_address,
  input  logic [LINE_W-1:0] i_wdata,
  output logic              i_resp,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_resp,
  output logic [LINE_W-1:0] d_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_resp,
  input  logic [LINE_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, HOLDOFF} state_t;

  state_t              state_q, state_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic                i_req, d_req;
  logic                grant_i, grant_d;

  assign i_req = i_read | i_write;
  assign d_req = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_i_q, last_i_d;

  // On contention the client that was not served last wins.
  always_comb begin
    grant_d = d_req & (~i_req | last_i_q);
    grant_i = i_req & ~grant_d;
  end
`else
  always_comb begin
    grant_d = d_req;
    grant_i = i_req & ~d_req;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_i_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_i_q <= last_i_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_i_d = last_i_q;
`endif
    case (state_q)
      IDLE: begin
        // A simultaneous read+write from one client is taken as a write.
        if (grant_d) begin
          state_d = SERVE_D;
          wr_d    = d_write;
          rd_d    = d_read & ~d_write;
          addr_d  = d_address;
          wdata_d = d_wdata;
`ifdef ARB_ROUND_ROBIN_EN
          last_i_d = 1'b0;
`endif
        end else if (grant_i) begin
          state_d = SERVE_I;
          wr_d    = i_write;
          rd_d    = i_read & ~i_write;
          addr_d  = i_address;
          wdata_d = i_wdata;
`ifdef ARB_ROUND_ROBIN_EN
          last_i_d = 1'b1;
`endif
        end
      end
      SERVE_I, SERVE_D: if (mem_resp) state_d = HOLDOFF;
      default: state_d = IDLE;
    endcase
  end

  // Responses are suppressed while reset is asserted so an abandoned transaction never completes.
  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    i_resp      = 1'b0;
    d_resp      = 1'b0;
    mem_address = addr_q;
    mem_wdata   = wdata_q;
    if (state_q == SERVE_I || state_q == SERVE_D) begin
      mem_read  = rd_q;
      mem_write = wr_q;
    end
    if (state_q == SERVE_I) i_resp = mem_resp & rst_n;
    if (state_q == SERVE_D) d_resp = mem_resp & rst_n;
  end

  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: per-cycle vector table plus hand-written corner sequences.
module tb_cache_mem_arbiter;
  localparam int ADDR_W = 16;
  localparam int LINE_W = 128;
  localparam logic [LINE_W-1:0] I_WD = {8{16'h1111}};
  localparam logic [LINE_W-1:0] D_WD = {8{16'hDDDD}};
  localparam logic [LINE_W-1:0] RD   = {16{8'hA5}};

  logic clk = 1'b0;
  logic rst_n;
  logic i_read, i_write, d_read, d_write, mem_resp;
  logic [ADDR_W-1:0] i_address, d_address;
  logic [LINE_W-1:0] i_wdata, d_wdata, mem_rdata;
  logic i_resp, d_resp, mem_read, mem_write;
  logic [LINE_W-1:0] i_rdata, d_rdata, mem_wdata;
  logic [ADDR_W-1:0] mem_address;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cache_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_write(i_write), .i_address(i_address), .i_wdata(i_wdata),
    .i_resp(i_resp), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_resp(d_resp), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        rst_n, ir, iw;
    logic [15:0] ia;
    logic        dr, dw;
    logic [15:0] da;
    logic        mr;
    logic        e_rd, e_wr;
    logic [15:0] e_addr;
    int          e_ws;  // 0: zero, 1: I-cache data, 2: D-cache data
    logic        e_ir, e_dr;
  } vec_t;

  vec_t tbl[23];

  function automatic vec_t mk(logic r, logic ir, logic iw, logic [15:0] ia, logic dr, logic dw,
                              logic [15:0] da, logic mr, logic erd, logic ewr, logic [15:0] ea,
                              int ews, logic eir, logic edr);
    vec_t v;
    v.rst_n = r; v.ir = ir; v.iw = iw; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.mr = mr;
    v.e_rd = erd; v.e_wr = ewr; v.e_addr = ea; v.e_ws = ews; v.e_ir = eir; v.e_dr = edr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic ir, input logic iw, input logic [15:0] ia,
                       input logic dr, input logic dw, input logic [15:0] da, input logic mr);
    rst_n = r; i_read = ir; i_write = iw; i_address = ia;
    d_read = dr; d_write = dw; d_address = da; mem_resp = mr;
  endtask

  // Inputs change just after the rising edge; outputs are checked on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [LINE_W-1:0] ews_val;
    string tag;
    //            rst ir iw ia       dr dw da       mr | rd wr addr   ws ir dr
    tbl[0]  = mk(0, 1, 0, 16'h1230, 0, 0, 16'h0000, 0,  0, 0, 16'h0000, 0, 0, 0);
    tbl[1]  = mk(0, 1, 0, 16'h1230, 0, 0, 16'h0000, 0,  0, 0, 16'h0000, 0, 0, 0);
    tbl[2]  = mk(0, 1, 0, 16'h1230, 0, 0, 16'h0000, 0,  0, 0, 16'h0000, 0, 0, 0);
    tbl[3]  = mk(1, 1, 0, 16'h1230, 0, 0, 16'h0000, 0,  0, 0, 16'h0000, 0, 0, 0);
    tbl[4]  = mk(1, 1, 0, 16'h1230, 0, 0, 16'h0000, 0,  1, 0, 16'h1230, 1, 0, 0);
    tbl[5]  = mk(1, 1, 0, 16'h1230, 0, 0, 16'h0000, 0,  1, 0, 16'h1230, 1, 0, 0);
    tbl[6]  = mk(1, 1, 0, 16'h1230, 0, 0, 16'h0000, 0,  1, 0, 16'h1230, 1, 0, 0);
    tbl[7]  = mk(1, 1, 0, 16'h1230, 0, 0, 16'h0000, 1,  1, 0, 16'h1230, 1, 1, 0);
    tbl[8]  = mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 1,  0, 0, 16'h1230, 1, 0, 0);
    tbl[9]  = mk(1, 1, 0, 16'h0040, 0, 1, 16'h8000, 0,  0, 0, 16'h1230, 1, 0, 0);
    tbl[10] = mk(1, 1, 0, 16'h0040, 0, 1, 16'h8000, 0,  0, 1, 16'h8000, 2, 0, 0);
    tbl[11] = mk(1, 1, 0, 16'h0040, 0, 0, 16'h9990, 0,  0, 1, 16'h8000, 2, 0, 0);
    tbl[12] = mk(1, 1, 0, 16'h0040, 0, 0, 16'h9990, 1,  0, 1, 16'h8000, 2, 0, 1);
    tbl[13] = mk(1, 1, 0, 16'h0040, 0, 0, 16'h0000, 0,  0, 0, 16'h8000, 2, 0, 0);
    tbl[14] = mk(1, 1, 0, 16'h0040, 0, 0, 16'h0000, 0,  0, 0, 16'h8000, 2, 0, 0);
    tbl[15] = mk(1, 1, 0, 16'h0040, 0, 0, 16'h0000, 1,  1, 0, 16'h0040, 1, 1, 0);
    tbl[16] = mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0,  0, 0, 16'h0040, 1, 0, 0);
    tbl[17] = mk(1, 1, 1, 16'h0100, 0, 0, 16'h0000, 0,  0, 0, 16'h0040, 1, 0, 0);
    tbl[18] = mk(1, 1, 1, 16'h0100, 0, 0, 16'h0000, 0,  0, 1, 16'h0100, 1, 0, 0);
    tbl[19] = mk(1, 1, 1, 16'h0100, 0, 0, 16'h0000, 0,  0, 1, 16'h0100, 1, 0, 0);
    tbl[20] = mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1,  0, 1, 16'h0100, 1, 0, 0);
    tbl[21] = mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 1,  0, 0, 16'h0000, 0, 0, 0);
    tbl[22] = mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0,  0, 0, 16'h0000, 0, 0, 0);

    i_wdata = I_WD; d_wdata = D_WD; mem_rdata = RD;
    drive(0, 0, 0, 16'h0, 0, 0, 16'h0, 0);
    next_cycle();

    for (int k = 0; k < 23; k++) begin
      drive(tbl[k].rst_n, tbl[k].ir, tbl[k].iw, tbl[k].ia, tbl[k].dr, tbl[k].dw, tbl[k].da, tbl[k].mr);
      @(negedge clk);
      tag = $sformatf("row%0d", k);
      ews_val = (tbl[k].e_ws == 1) ? I_WD : (tbl[k].e_ws == 2) ? D_WD : '0;
      chk({tag, ".mem_read"},    {127'b0, mem_read},  {127'b0, tbl[k].e_rd});
      chk({tag, ".mem_write"},   {127'b0, mem_write}, {127'b0, tbl[k].e_wr});
      chk({tag, ".mem_address"}, {112'b0, mem_address}, {112'b0, tbl[k].e_addr});
      chk({tag, ".mem_wdata"},   mem_wdata, ews_val);
      chk({tag, ".i_resp"},      {127'b0, i_resp}, {127'b0, tbl[k].e_ir});
      chk({tag, ".d_resp"},      {127'b0, d_resp}, {127'b0, tbl[k].e_dr});
      if (tbl[k].e_ir) chk({tag, ".i_rdata"}, i_rdata, RD);
      if (tbl[k].e_dr) chk({tag, ".d_rdata"}, d_rdata, RD);
      next_cycle();
    end

    // D read alone with mem_resp in the first serving cycle (minimum latency).
    drive(1, 0, 0, 16'h0, 1, 0, 16'h2220, 0);
    @(negedge clk);
    chk("minlat.idle_read", {127'b0, mem_read}, 128'd0);
    next_cycle();
    drive(1, 0, 0, 16'h0, 1, 0, 16'h2220, 1);
    @(negedge clk);
    chk("minlat.mem_read", {127'b0, mem_read}, 128'd1);
    chk("minlat.addr", {112'b0, mem_address}, 128'h2220);
    chk("minlat.d_resp", {127'b0, d_resp}, 128'd1);
    chk("minlat.i_resp", {127'b0, i_resp}, 128'd0);
    chk("minlat.d_rdata", d_rdata, RD);
    next_cycle();
    drive(1, 0, 0, 16'h0, 0, 0, 16'h0, 0);
    @(negedge clk);
    chk("minlat.holdoff", {127'b0, mem_read}, 128'd0);
    next_cycle();

    // Contention right after serving D: round robin picks I, fixed priority picks D again.
    drive(1, 1, 0, 16'h0040, 1, 0, 16'h0050, 0);
    @(negedge clk);
    chk("contend.idle", {127'b0, mem_read}, 128'd0);
    next_cycle();
    drive(1, 1, 0, 16'h0040, 1, 0, 16'h0050, 1);
    @(negedge clk);
    chk("contend.mem_read", {127'b0, mem_read}, 128'd1);
`ifdef ARB_ROUND_ROBIN_EN
    chk("contend.addr", {112'b0, mem_address}, 128'h0040);
    chk("contend.i_resp", {127'b0, i_resp}, 128'd1);
    chk("contend.d_resp", {127'b0, d_resp}, 128'd0);
`else
    chk("contend.addr", {112'b0, mem_address}, 128'h0050);
    chk("contend.i_resp", {127'b0, i_resp}, 128'd0);
    chk("contend.d_resp", {127'b0, d_resp}, 128'd1);
`endif
    next_cycle();
    drive(1, 0, 0, 16'h0, 0, 0, 16'h0, 0);
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
